// File: rtl/baud_sched.sv
// Baud-rate change scheduler: arbitrates two requesters, waits for an idle line,
// restarts baud_gen at the new rate and lets a few baud ticks settle before acking.
module baud_sched #(
    parameter logic [1:0]  DEFAULT_RATE = 2'b00,
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned GUARD_TICKS  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [1:0] rate_a,
    input  logic       req_b,
    input  logic [1:0] rate_b,
    input  logic       busy,
    input  logic       baud_tick,
    output logic [1:0] baud_rate,
    output logic       gen_rst,
    output logic       cfg_valid,
    output logic       ack_a,
    output logic       ack_b
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        APPLY,
        GUARD,
        DONE
    } state_t;

    state_t             state;
    logic [1:0]         rate_q;
    logic               gnt_b;
    logic               last_b;
    logic [CNT_W-1:0]   rst_cnt;
    logic [CNT_W-1:0]   tick_cnt;
    logic               tick_q;

    logic               tick_rise_c;
    logic               gnt_req_c;
    logic               pick_b_c;

    // B wins only when A is absent or A was the last one served
    always_comb begin
        tick_rise_c = baud_tick & ~tick_q & ~gen_rst;
        gnt_req_c   = gnt_b ? req_b : req_a;
        pick_b_c    = req_b & (~req_a | ~last_b);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rate_q    <= DEFAULT_RATE;
            gnt_b     <= 1'b0;
            last_b    <= 1'b1;
            rst_cnt   <= '0;
            tick_cnt  <= '0;
            tick_q    <= 1'b0;
            baud_rate <= DEFAULT_RATE;
            gen_rst   <= 1'b0;
            cfg_valid <= 1'b1;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
        end else begin
            tick_q <= baud_tick;
            ack_a  <= 1'b0;
            ack_b  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        gnt_b     <= pick_b_c;
                        last_b    <= pick_b_c;
                        rate_q    <= pick_b_c ? rate_b : rate_a;
                        cfg_valid <= 1'b0;
                        state     <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (!gnt_req_c) begin
                        cfg_valid <= 1'b1;
                        state     <= IDLE;
                    end else if (rate_q == baud_rate) begin
                        ack_a     <= ~gnt_b;
                        ack_b     <= gnt_b;
                        cfg_valid <= 1'b1;
                        state     <= DONE;
                    end else if (!busy) begin
                        baud_rate <= rate_q;
                        gen_rst   <= 1'b1;
                        rst_cnt   <= '0;
                        state     <= APPLY;
                    end
                end
                APPLY: begin
                    if (rst_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        gen_rst  <= 1'b0;
                        tick_cnt <= '0;
                        state    <= GUARD;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                GUARD: begin
                    if (tick_rise_c) begin
                        if (tick_cnt == CNT_W'(GUARD_TICKS - 1)) begin
                            ack_a     <= ~gnt_b;
                            ack_b     <= gnt_b;
                            cfg_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_baud_sched.sv
// Directed self-checking bench for baud_sched with default parameters.
module tb_baud_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a;
    logic [1:0] rate_a;
    logic       req_b;
    logic [1:0] rate_b;
    logic       busy;
    logic       baud_tick;
    logic [1:0] baud_rate;
    logic       gen_rst;
    logic       cfg_valid;
    logic       ack_a;
    logic       ack_b;

    int checks = 0;
    int errors = 0;

    baud_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .rate_a    (rate_a),
        .req_b     (req_b),
        .rate_b    (rate_b),
        .busy      (busy),
        .baud_tick (baud_tick),
        .baud_rate (baud_rate),
        .gen_rst   (gen_rst),
        .cfg_valid (cfg_valid),
        .ack_a     (ack_a),
        .ack_b     (ack_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // baud_rate, gen_rst, cfg_valid, ack_a, ack_b in one go
    task automatic check_all(input string tag, input logic [1:0] br, input logic gr,
                             input logic cv, input logic aa, input logic ab);
        check({tag, ".baud_rate"}, 32'(baud_rate), 32'(br));
        check({tag, ".gen_rst"},   32'(gen_rst),   32'(gr));
        check({tag, ".cfg_valid"}, 32'(cfg_valid), 32'(cv));
        check({tag, ".ack_a"},     32'(ack_a),     32'(aa));
        check({tag, ".ack_b"},     32'(ack_b),     32'(ab));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all("rst_async", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        cyc();
        check_all("rst_hold", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        check_all("rst_idle", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; req_a = 1'b0; rate_a = 2'b00; req_b = 1'b0; rate_b = 2'b00;
        busy = 1'b0; baud_tick = 1'b0;
        #1 rst = 1'b0;
        #1 check_all("por", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        rst = 1'b1;
        cyc();

        // Basic switch to rate 2 through APPLY and GUARD
        req_a = 1'b1; rate_a = 2'b10;
        cyc();
        check_all("sw.wait", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_all("sw.apply", 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        cyc();
        check_all("sw.guard", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        baud_tick = 1'b1;
        cyc();
        check_all("sw.tick1", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        baud_tick = 1'b0;
        cyc();
        check_all("sw.tick1lo", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        baud_tick = 1'b1;
        cyc();
        check_all("sw.ack", 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        baud_tick = 1'b0; req_a = 1'b0;
        cyc();
        check_all("sw.after", 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        check_all("sw.after2", 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);

        // Round robin: A takes the first tie after reset, B the next
        do_reset();
        req_a = 1'b1; rate_a = 2'b00; req_b = 1'b1; rate_b = 2'b00;
        cyc();
        check_all("rr.wait1", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        check_all("rr.ack_a", 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc();
        check_all("rr.idle", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        check_all("rr.wait2", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        check_all("rr.ack_b", 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        req_a = 1'b0; req_b = 1'b0;
        cyc();
        check_all("rr.done", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Switch held off by busy, then proceeds; busy during APPLY is ignored
        req_b = 1'b1; rate_b = 2'b01; busy = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cyc();
            check_all("busy.hold", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        busy = 1'b0;
        cyc();
        check_all("busy.apply1", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        busy = 1'b1; baud_tick = 1'b1;
        cyc();
        check_all("busy.apply2", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        baud_tick = 1'b0;
        cyc();
        check_all("busy.apply3", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        check_all("busy.apply4", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        check_all("busy.guard", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        baud_tick = 1'b1;
        cyc();
        check_all("busy.tick1", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        baud_tick = 1'b0;
        cyc();
        baud_tick = 1'b1;
        cyc();
        check_all("busy.ack_b", 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
        baud_tick = 1'b0; req_b = 1'b0; busy = 1'b0;
        cyc();
        check_all("busy.after", 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);

        // Same rate requested: fast ack, no restart
        req_a = 1'b1; rate_a = 2'b01;
        cyc();
        check_all("same.wait", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        check_all("same.ack", 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
        req_a = 1'b0;
        cyc();
        check_all("same.after", 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);

        // Withdrawal while waiting for busy
        busy = 1'b1; req_a = 1'b1; rate_a = 2'b11;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_all("wd.wait", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        req_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_all("wd.idle", 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        busy = 1'b0;

        // Reset during GUARD aborts with no ack
        req_a = 1'b1; rate_a = 2'b10;
        cyc();
        cyc();
        check_all("ab.apply", 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(); cyc(); cyc(); cyc();
        check_all("ab.guard", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        baud_tick = 1'b1;
        cyc();
        baud_tick = 1'b0;
        #2 rst = 1'b0;
        #1 check_all("ab.rst", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        req_a = 1'b0;
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            baud_tick = ~baud_tick;
            cyc();
            check_all("ab.noack", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
